// File: rtl/isp_pkg.sv
// Shared ISP constants and knot-table types for the gamma stage.
// Holds pixel/segment widths, the knot table type and its identity-curve
// reset value.
package isp_pkg;

  localparam int unsigned PIXEL_WIDTH = 16;
  localparam int unsigned SEG_BITS    = 5;
  localparam int unsigned FRAC_W      = PIXEL_WIDTH - SEG_BITS;
  localparam int unsigned N_KNOTS     = (1 << SEG_BITS) + 1;
  localparam int unsigned IDX_W       = SEG_BITS + 1;

  typedef logic [PIXEL_WIDTH-1:0] knot_t;
  typedef knot_t [N_KNOTS-1:0]    knot_tbl_t;

  // Identity curve: knot i sits at i*2^FRAC_W, last knot pinned to full scale.
  function automatic knot_tbl_t knot_identity();
    knot_tbl_t t;
    for (int unsigned i = 0; i < N_KNOTS - 1; i++) begin
      t[i] = knot_t'(i << FRAC_W);
    end
    t[N_KNOTS-1] = '1;
    return t;
  endfunction

endpackage

// File: rtl/gamma_interp.sv
// One channel of the gamma datapath, stages S2 and S3.
// S2 forms the signed slope product (hi-lo)*frac and keeps lo/bypass/raw.
// S3 rounds, adds lo, clips to the pixel range and applies the bypass mux.
// Ports: clk, reset (async active-low), s1_valid/s2_valid stage enables,
//        lo/hi knots, frac, byp, raw pixel in; y corrected pixel out (held).
module gamma_interp
  import isp_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s1_valid,
  input  logic                   s2_valid,
  input  logic [PIXEL_WIDTH-1:0] lo,
  input  logic [PIXEL_WIDTH-1:0] hi,
  input  logic [FRAC_W-1:0]      frac,
  input  logic                   byp,
  input  logic [PIXEL_WIDTH-1:0] raw,
  output logic [PIXEL_WIDTH-1:0] y
);

  localparam int unsigned D_W    = PIXEL_WIDTH + 1;
  localparam int unsigned PROD_W = D_W + FRAC_W + 1;
  localparam int unsigned SUM_W  = PIXEL_WIDTH + 3;

  logic signed [D_W-1:0]    diff_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [PROD_W-1:0] prod_q;
  logic [PIXEL_WIDTH-1:0]   lo_q;
  logic [PIXEL_WIDTH-1:0]   raw_q;
  logic                     byp_q;
  logic signed [PROD_W-1:0] rnd_c;
  logic signed [PROD_W-1:0] shift_c;
  logic signed [SUM_W-1:0]  sum_c;
  logic [PIXEL_WIDTH-1:0]   clip_c;

  // Slope may be negative for descending curves, so both operands are signed.
  assign diff_c = $signed({1'b0, hi}) - $signed({1'b0, lo});
  assign prod_c = PROD_W'(diff_c) * PROD_W'($signed({1'b0, frac}));

  // S2 register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q <= '0;
      lo_q   <= '0;
      raw_q  <= '0;
      byp_q  <= 1'b0;
    end else if (s1_valid) begin
      prod_q <= prod_c;
      lo_q   <= lo;
      raw_q  <= raw;
      byp_q  <= byp;
    end
  end

  // Round half up, arithmetic shift keeps negative slopes correct.
  assign rnd_c   = prod_q + PROD_W'(1 << (FRAC_W - 1));
  assign shift_c = rnd_c >>> FRAC_W;
  assign sum_c   = SUM_W'(shift_c) + $signed(SUM_W'(lo_q));

  // Saturate to the unsigned pixel range.
  always_comb begin
    clip_c = sum_c[PIXEL_WIDTH-1:0];
    if (sum_c[SUM_W-1]) begin
      clip_c = '0;
    end else if (|sum_c[SUM_W-2:PIXEL_WIDTH]) begin
      clip_c = '1;
    end
  end

  // S3 register: output holds between valid pixels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y <= '0;
    end else if (s2_valid) begin
      y <= byp_q ? raw_q : clip_c;
    end
  end

endmodule

// File: rtl/gamma_lut.sv
// Per-channel programmable 33-knot piecewise-linear gamma stage.
// Owns the shared knot table, the S1 knot lookup, and valid/done tracking;
// three gamma_interp instances do the per-channel S2/S3 arithmetic.
// Ports: clk, reset (async active-low), data_ready + pixel_in_{red,green,blue},
//        bypass, ccm_done, lut_we/lut_addr/lut_data knot writes;
//        data_valid + pixel_out_{red,green,blue}, done.
module gamma_lut
  import isp_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   data_ready,
  input  logic [PIXEL_WIDTH-1:0] pixel_in_red,
  input  logic [PIXEL_WIDTH-1:0] pixel_in_green,
  input  logic [PIXEL_WIDTH-1:0] pixel_in_blue,
  input  logic                   bypass,
  input  logic                   ccm_done,
  input  logic                   lut_we,
  input  logic [SEG_BITS:0]      lut_addr,
  input  logic [PIXEL_WIDTH-1:0] lut_data,
  output logic                   data_valid,
  output logic [PIXEL_WIDTH-1:0] pixel_out_red,
  output logic [PIXEL_WIDTH-1:0] pixel_out_green,
  output logic [PIXEL_WIDTH-1:0] pixel_out_blue,
  output logic                   done
);

  localparam int unsigned N_CH = 3;

  knot_tbl_t                          tbl_q;
  logic [N_CH-1:0][PIXEL_WIDTH-1:0]   pix_c;
  logic [N_CH-1:0][IDX_W-1:0]         seg_c;
  logic [N_CH-1:0][PIXEL_WIDTH-1:0]   lo_c;
  logic [N_CH-1:0][PIXEL_WIDTH-1:0]   hi_c;
  logic [N_CH-1:0][PIXEL_WIDTH-1:0]   lo_q;
  logic [N_CH-1:0][PIXEL_WIDTH-1:0]   hi_q;
  logic [N_CH-1:0][PIXEL_WIDTH-1:0]   raw_q;
  logic [N_CH-1:0][FRAC_W-1:0]        frac_q;
  logic [N_CH-1:0][PIXEL_WIDTH-1:0]   y;
  logic                               byp_q;
  logic                               v1_q;
  logic                               v2_q;
  logic                               v3_q;
  logic [2:0]                         done_sr_q;

  assign pix_c = {pixel_in_blue, pixel_in_green, pixel_in_red};

  // Knot table; out-of-range addresses are dropped. A same-cycle S1 read
  // sees the pre-write value since both sample tbl_q at the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tbl_q <= knot_identity();
    end else if (lut_we && (lut_addr < IDX_W'(N_KNOTS))) begin
      tbl_q[lut_addr] <= lut_data;
    end
  end

  // Segment lookup: top SEG_BITS select the segment, its two end knots.
  always_comb begin
    seg_c = '0;
    lo_c  = '0;
    hi_c  = '0;
    for (int c = 0; c < N_CH; c++) begin
      seg_c[c] = IDX_W'(pix_c[c][PIXEL_WIDTH-1 -: SEG_BITS]);
      lo_c[c]  = tbl_q[seg_c[c]];
      hi_c[c]  = tbl_q[seg_c[c] + IDX_W'(1)];
    end
  end

  // S1 register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_q   <= '0;
      hi_q   <= '0;
      raw_q  <= '0;
      frac_q <= '0;
      byp_q  <= 1'b0;
    end else if (data_ready) begin
      lo_q  <= lo_c;
      hi_q  <= hi_c;
      raw_q <= pix_c;
      byp_q <= bypass;
      for (int c = 0; c < N_CH; c++) begin
        frac_q[c] <= pix_c[c][FRAC_W-1:0];
      end
    end
  end

  // Valid and frame-done tracking, same three-cycle latency as the data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      done_sr_q <= '0;
    end else begin
      v1_q      <= data_ready;
      v2_q      <= v1_q;
      v3_q      <= v2_q;
      done_sr_q <= {done_sr_q[1:0], ccm_done};
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_chan
    gamma_interp u_interp (
      .clk      (clk),
      .reset    (reset),
      .s1_valid (v1_q),
      .s2_valid (v2_q),
      .lo       (lo_q[c]),
      .hi       (hi_q[c]),
      .frac     (frac_q[c]),
      .byp      (byp_q),
      .raw      (raw_q[c]),
      .y        (y[c])
    );
  end

  assign data_valid      = v3_q;
  assign done            = done_sr_q[2];
  assign pixel_out_red   = y[0];
  assign pixel_out_green = y[1];
  assign pixel_out_blue  = y[2];

endmodule

// File: tb/tb_gamma_lut.sv
// Scoreboard bench for gamma_lut: expected pixels and done pulses are queued
// with their due cycle when driven, and checked every falling edge.
module tb_gamma_lut;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        data_ready = 1'b0;
  logic        bypass = 1'b0;
  logic        ccm_done = 1'b0;
  logic        lut_we = 1'b0;
  logic [5:0]  lut_addr = '0;
  logic [15:0] lut_data = '0;
  logic [15:0] pir = '0, pig = '0, pib = '0;
  logic        data_valid, done;
  logic [15:0] por, pog, pob;

  gamma_lut dut (
    .clk             (clk),
    .reset           (reset),
    .data_ready      (data_ready),
    .pixel_in_red    (pir),
    .pixel_in_green  (pig),
    .pixel_in_blue   (pib),
    .bypass          (bypass),
    .ccm_done        (ccm_done),
    .lut_we          (lut_we),
    .lut_addr        (lut_addr),
    .lut_data        (lut_data),
    .data_valid      (data_valid),
    .pixel_out_red   (por),
    .pixel_out_green (pog),
    .pixel_out_blue  (pob),
    .done            (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] r, g, b;
  } exp_t;

  exp_t sb[$];
  int   done_q[$];
  int   mk[33];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%h exp=0x%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_identity();
    for (int i = 0; i < 32; i++) mk[i] = i * 2048;
    mk[32] = 65535;
  endfunction

  // Reference curve with explicit floor division for negative slopes.
  function automatic logic [15:0] model(input logic [15:0] p, input logic byp);
    int     seg, f;
    longint d, num, q, y;
    if (byp) return p;
    seg = int'(p) / 2048;
    f   = int'(p) % 2048;
    d   = longint'(mk[seg + 1]) - longint'(mk[seg]);
    num = d * f + 1024;
    q   = (num >= 0) ? num / 2048 : -((-num + 2047) / 2048);
    y   = longint'(mk[seg]) + q;
    if (y < 0) y = 0;
    if (y > 65535) y = 65535;
    return 16'(y);
  endfunction

  task automatic drive(input logic dr, input logic [15:0] r, input logic [15:0] g,
                       input logic [15:0] b, input logic byp, input logic cd,
                       input logic we, input logic [5:0] a, input logic [15:0] d);
    exp_t e;
    data_ready = dr; pir = r; pig = g; pib = b; bypass = byp;
    ccm_done = cd; lut_we = we; lut_addr = a; lut_data = d;
    if (dr) begin
      e.cyc = cyc + 3;
      e.r = model(r, byp); e.g = model(g, byp); e.b = model(b, byp);
      sb.push_back(e);
    end
    if (cd) done_q.push_back(cyc + 3);
    if (we && a < 6'd33) mk[a] = int'(d);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic pix(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b,
                     input logic byp);
    drive(1'b1, r, g, b, byp, 1'b0, 1'b0, '0, '0);
  endtask

  // Pixel with hand-derived expected outputs instead of the model's.
  task automatic pixk(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b,
                      input logic byp, input logic [15:0] er, input logic [15:0] eg,
                      input logic [15:0] eb);
    drive(1'b1, r, g, b, byp, 1'b0, 1'b0, '0, '0);
    sb[sb.size()-1].r = er;
    sb[sb.size()-1].g = eg;
    sb[sb.size()-1].b = eb;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, a, d);
  endtask

  // Cycle-accurate monitor: valid and done must match the queued due cycles.
  always @(negedge clk) begin : mon
    exp_t e;
    logic ev, dv;
    ev = (sb.size() > 0) && (sb[0].cyc == cyc);
    check("data_valid", 16'(data_valid), 16'(ev));
    if (ev) begin
      e = sb.pop_front();
      check("red", por, e.r);
      check("green", pog, e.g);
      check("blue", pob, e.b);
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      void'(sb.pop_front());
    end
    dv = (done_q.size() > 0) && (done_q[0] == cyc);
    check("done", 16'(done), 16'(dv));
    if (dv || (done_q.size() > 0 && done_q[0] < cyc)) void'(done_q.pop_front());
  end

  initial begin
    logic [15:0] hold_v;
    model_identity();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_red", por, 16'h0000);
    check("rst_green", pog, 16'h0000);
    check("rst_blue", pob, 16'h0000);
    check("rst_valid", 16'(data_valid), 16'h0);
    reset = 1'b1;
    idle(2);

    // Identity curve, 8 back-to-back pixels.
    pixk(16'h0000, 16'h4000, 16'h8000, 1'b0, 16'h0000, 16'h4000, 16'h8000);
    pixk(16'hFFFF, 16'hFFFF, 16'h8000, 1'b0, 16'hFFFE, 16'hFFFE, 16'h8000);
    for (int i = 0; i < 6; i++) pix(16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    idle(5);

    // Single pulse, then outputs must hold.
    hold_v = model(16'h2345, 1'b0);
    pix(16'h2345, 16'h2345, 16'h2345, 1'b0);
    idle(6);
    check("hold_red", por, hold_v);
    check("hold_blue", pob, hold_v);

    // Flat curve.
    for (int a = 0; a < 33; a++) wr(6'(a), 16'h1000);
    pixk(16'h0000, 16'h7ABC, 16'hFFFF, 1'b0, 16'h1000, 16'h1000, 16'h1000);
    // Out-of-range writes must not alias onto real knots.
    wr(6'd33, 16'h0000);
    wr(6'd63, 16'h0000);
    pixk(16'h0800, 16'hFFFF, 16'h0000, 1'b0, 16'h1000, 16'h1000, 16'h1000);
    idle(4);

    // Descending first segment, signed rounding.
    wr(6'd0, 16'hFFFF);
    wr(6'd1, 16'h0000);
    pixk(16'h0400, 16'h0400, 16'h0400, 1'b0, 16'd32768, 16'd32768, 16'd32768);
    idle(4);

    // Write to k[2] in the same cycle a seg-2 pixel enters: old value first.
    drive(1'b1, 16'h1000, 16'h1000, 16'h1000, 1'b0, 1'b0, 1'b1, 6'd2, 16'h0000);
    sb[sb.size()-1].r = 16'h1000;
    sb[sb.size()-1].g = 16'h1000;
    sb[sb.size()-1].b = 16'h1000;
    pixk(16'h1000, 16'h1000, 16'h1000, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    idle(4);

    // Bypass mixed into a stream, done on the last pixel.
    pixk(16'h1234, 16'h1234, 16'h1234, 1'b1, 16'h1234, 16'h1234, 16'h1234);
    pix(16'h0400, 16'h0401, 16'h1001, 1'b0);
    drive(1'b1, 16'hBEEF, 16'h0001, 16'hFFFF, 1'b1, 1'b1, 1'b0, '0, '0);
    idle(5);

    // Random curve and random stream.
    for (int a = 0; a < 33; a++) wr(6'(a), 16'($urandom));
    for (int i = 0; i < 20; i++)
      pix(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
    idle(5);

    // Reset with pixels in flight: nothing may emerge, knots return to identity.
    pix(16'h1111, 16'h2222, 16'h3333, 1'b0);
    pix(16'h4444, 16'h5555, 16'h6666, 1'b0);
    data_ready = 1'b1; pir = 16'h7777; pig = 16'h8888; pib = 16'h9999;
    ccm_done = 1'b1;
    reset = 1'b0;
    sb.delete();
    done_q.delete();
    #1;
    check("async_rst_red", por, 16'h0000);
    check("async_rst_valid", 16'(data_valid), 16'h0);
    check("async_rst_done", 16'(done), 16'h0);
    @(posedge clk); #1;
    idle(2);
    model_identity();
    reset = 1'b1;
    idle(6);
    check("post_rst_red", por, 16'h0000);
    check("post_rst_green", pog, 16'h0000);
    pixk(16'hFFFF, 16'h8000, 16'h4000, 1'b0, 16'hFFFE, 16'h8000, 16'h4000);
    idle(6);

    check("sb_drained", 16'(sb.size()), 16'h0);
    check("done_drained", 16'(done_q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gamma_lut.md
Name: gamma_lut

Overview:
- Per-channel tone/gamma stage directly downstream of colorspace conversion.
- Consumes the converted RGB pixels and their data_valid/done and applies one programmable 33-knot piecewise-linear curve to each channel.
- Three-stage fixed-latency pipeline with no backpressure, matching the upstream streaming contract.
- Output feeds the pixel packer/writer.

Parameters:
- PIXEL_WIDTH, 16, bits per colour channel in and out.
- SEG_BITS, 5, log2 of the segment count: 32 segments, 33 knots.
- FRAC_W, PIXEL_WIDTH-SEG_BITS (11), interpolation fraction width. Derived; do not override.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- data_ready  in  1  input pixel valid this cycle (upstream data_valid).
- pixel_in_red  in  PIXEL_WIDTH  converted red.
- pixel_in_green  in  PIXEL_WIDTH  converted green.
- pixel_in_blue  in  PIXEL_WIDTH  converted blue.
- bypass  in  1  1 = pass pixel unchanged; sampled with each pixel.
- ccm_done  in  1  upstream frame-done.
- lut_we  in  1  knot write strobe.
- lut_addr  in  SEG_BITS+1  knot index, 0..32.
- lut_data  in  PIXEL_WIDTH  knot value, unsigned.
- data_valid  out  1  output pixel valid.
- pixel_out_red  out  PIXEL_WIDTH  corrected red.
- pixel_out_green  out  PIXEL_WIDTH  corrected green.
- pixel_out_blue  out  PIXEL_WIDTH  corrected blue.
- done  out  1  frame-done aligned with the last output pixel.

Behaviour:
- Reset (reset=0, async):
  - data_valid=0, done=0, pixel_out_*=0.
  - All pipeline valid bits cleared; in-flight pixels are discarded, never emitted.
  - Knot table loads identity: k[i]=i*2048 for i=0..31, k[32]=65535.
- Knot table: 33 x PIXEL_WIDTH flops, one curve shared by all three channels.
  - lut_we=1 writes lut_data to k[lut_addr] at the clock edge.
  - lut_addr>32: write ignored.
  - Writes are legal while streaming. A stage-1 read in the same cycle as a write sees the old value; the new value applies from the next cycle.
- Per-channel arithmetic for pixel p:
  - seg = p[15:11], f = p[10:0].
  - lo = k[seg], hi = k[seg+1].
  - d = hi - lo, signed PIXEL_WIDTH+1 bits.
  - prod = d * {0,f}, signed 29 bits.
  - y = lo + ((prod + 1024) >>> 11), arithmetic shift.
  - Clip y to [0, 65535]. This is defensive: it is unreachable with in-range knots but must still be implemented.
  - bypass=1: y = p.
- Pipeline, with no stalls:
  - S1 registers lo, hi, f and bypass/raw pixel per channel on data_ready.
  - S2 registers prod and lo.
  - S3 registers clipped y into pixel_out_*.
- Latency and handshake:
  - A pixel with data_ready high at edge N gives data_valid high for exactly one cycle after edge N+3.
  - Back-to-back data_ready gives back-to-back data_valid, one pixel per clock.
  - pixel_out_* hold their last value while data_valid=0.
- done: ccm_done delayed through a 3-flop shift register, so done has the same latency as data and coincides with or follows the last pixel.
- Simultaneous lut_we and data_ready is legal (see the knot-table rule above). bypass has no effect on done or data_valid timing.

Decomposition:
- isp_pkg holds:
  - PIXEL_WIDTH, SEG_BITS, FRAC_W, and N_KNOTS=33 constants.
  - typedef knot_t, logic [PIXEL_WIDTH-1:0].
  - typedef knot_tbl_t, knot_t [N_KNOTS-1:0].
  - the identity-reset function for knot_tbl_t.
- Sub-module gamma_interp: one channel's S2/S3 datapath (multiply, round, clip, bypass mux). Instantiated three times; the table, S1 and valid/done tracking stay in gamma_lut.

Test Plan:
- Reset identity curve:
  - pixels 0x0000 → 0x0000.
  - 0x4000 → 0x4000.
  - 0x8000 → 0x8000.
  - 0xFFFF → 0xFFFE (65534), since the top segment has slope 2047/2048.
- Latency and throughput:
  - Single data_ready pulse at edge N → data_valid only after edge N+3; outputs hold afterwards.
  - 8 consecutive pixels → 8 consecutive valids with no gaps.
- Program all knots to 0x1000 → R/G/B of 0x0000, 0x7ABC, 0xFFFF all → 0x1000.
- Program k[0]=65535, k[1]=0 → pixel 0x0400 → 32768 (descending slope, signed rounding).
- Write during stream:
  - lut_we to k[2]=0 in the same cycle as pixel 0x1000 (seg 2, f=0) enters → output 0x1000 (old value).
  - The same pixel one cycle later → 0x0000.
- Bypass, done and reset:
  - bypass=1 with pixel 0x1234 → 0x1234 at the same 3-cycle latency.
  - ccm_done pulse → done 3 cycles later.
  - reset asserted with 3 pixels in flight → no data_valid after release, outputs 0, knots back to identity.
